// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed N-digit seven-segment scanner.
// Hex nibbles, decimal points and blank masks are staged on load and committed
// to the display register only at a frame boundary, so a frame never mixes old
// and new digits. Each digit slot begins with a short all-off interval, and a
// PWM window set by brightness limits how long the digit is lit.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS      = 4,
    parameter int CLK_FREQ_HZ     = 50000000,
    parameter int REFRESH_RATE_HZ = 1000,
    parameter int BRIGHT_BITS     = 4,
    parameter int BLANK_CYCLES    = 2,
    parameter bit SEG_ACTIVE_LOW  = 1'b1,
    parameter bit DIG_ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [NUM_DIGITS-1:0]   dig,
    output logic [6:0]              abcdefg,
    output logic                    dp,
    output logic                    frame_done
);

    // Clock cycles spent on each digit, and the PWM step per brightness level.
    localparam int SLOT_COUNT = CLK_FREQ_HZ / (REFRESH_RATE_HZ * NUM_DIGITS);
    localparam int PWM_STEP   = SLOT_COUNT >> BRIGHT_BITS;
    localparam int CNT_W      = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Pin levels for the "off" state, after polarity.
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;

    // Lit-segment pattern (bit6 = a ... bit0 = g), before polarity.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Scan position
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    // Staging (written by load) and display (read by the scanner) registers
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] stg_data_q, stg_data_d;
    logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
    logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d;
    logic [4*NUM_DIGITS-1:0] dsp_data_q, dsp_data_d;
    logic [NUM_DIGITS-1:0]   dsp_dp_q, dsp_dp_d;
    logic [NUM_DIGITS-1:0]   dsp_blank_q, dsp_blank_d;
    // Registered pin drivers
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    frame_end;
    logic                    active;
    logic [31:0]             on_limit;
    logic [3:0]              cur_nib;

    assign frame_end = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    // Slot counter and digit index: cnt wraps each slot, idx steps on each wrap.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Staging capture (latest load wins) and frame-end commit, with a load in
    // the frame-end cycle bypassing straight into the display register.
    always_comb begin
        stg_data_d  = stg_data_q;
        stg_dp_d    = stg_dp_q;
        stg_blank_d = stg_blank_q;
        pending_d   = pending_q;
        dsp_data_d  = dsp_data_q;
        dsp_dp_d    = dsp_dp_q;
        dsp_blank_d = dsp_blank_q;
        if (load) begin
            stg_data_d  = data;
            stg_dp_d    = dp_in;
            stg_blank_d = blank;
            pending_d   = 1'b1;
        end
        if (frame_end) begin
            if (load) begin
                dsp_data_d  = data;
                dsp_dp_d    = dp_in;
                dsp_blank_d = blank;
            end else if (pending_q) begin
                dsp_data_d  = stg_data_q;
                dsp_dp_d    = stg_dp_q;
                dsp_blank_d = stg_blank_q;
            end
            pending_d = 1'b0;
        end
    end

    // Output decode for the current slot; registered so slot changes are glitch-free.
    always_comb begin
        on_limit = 32'(brightness) * 32'(PWM_STEP);
        cur_nib  = dsp_data_q[4*idx_q +: 4];
        active   = (32'(cnt_q) >= 32'(BLANK_CYCLES))
                && ((brightness == '1) || (32'(cnt_q) < on_limit))
                && !dsp_blank_q[idx_q];
        dig_d        = DIG_OFF;
        seg_d        = SEG_OFF;
        dp_d         = DP_OFF;
        frame_done_d = frame_end;
        if (active) begin
            dig_d = DIG_OFF ^ (NUM_DIGITS'(1) << idx_q);
            seg_d = SEG_OFF ^ hex_decode(cur_nib);
            dp_d  = DP_OFF ^ dsp_dp_q[idx_q];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            stg_data_q   <= '0;
            stg_dp_q     <= '0;
            stg_blank_q  <= '0;
            dsp_data_q   <= '0;
            dsp_dp_q     <= '0;
            dsp_blank_q  <= '0;
            dig_q        <= DIG_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            stg_data_q   <= stg_data_d;
            stg_dp_q     <= stg_dp_d;
            stg_blank_q  <= stg_blank_d;
            dsp_data_q   <= dsp_data_d;
            dsp_dp_q     <= dsp_dp_d;
            dsp_blank_q  <= dsp_blank_d;
            dig_q        <= dig_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dig        = dig_q;
    assign abcdefg    = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (SLOT_COUNT = 32, 4 digits, 128-cycle frame).
// Cycle n is the interval after the n-th rising edge. With reset released
// after edge 3, the output seen in cycle n shows frame position n-4.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp_in, blank;
    logic        load;
    logic [3:0]  brightness;
    logic [3:0]  dig;
    logic [6:0]  abcdefg;
    logic        dp, frame_done;

    seg7_scan_ctrl #(
        .NUM_DIGITS(4), .CLK_FREQ_HZ(12800), .REFRESH_RATE_HZ(100)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank(blank),
        .load(load), .brightness(brightness), .dig(dig), .abcdefg(abcdefg),
        .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Active-low segment patterns for the digits used below.
    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S4 = 7'b1001100, S6 = 7'b0100000,
                           S7 = 7'b0001111, S8 = 7'b0000000, S9 = 7'b0000100,
                           SB = 7'b1100000, SC = 7'b0110001, SD = 7'b1000010,
                           SE = 7'b0110000, SOFF = 7'h7F;

    typedef struct {
        int         n;
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   vectors = 0;
    int   errors  = 0;

    task automatic push(input int n, input logic [3:0] d, input logic [6:0] s,
                        input logic p, input logic f, input string nm);
        exp_t x;
        x.n = n; x.dig = d; x.seg = s; x.dp = p; x.fd = f; x.name = nm;
        q.push_back(x);
    endtask

    task automatic dark(input int n, input string nm);
        push(n, 4'b0000, SOFF, 1'b1, 1'b0, nm);
    endtask

    task automatic lit(input int n, input logic [3:0] d, input logic [6:0] s, input string nm);
        push(n, d, s, 1'b1, 1'b0, nm);
    endtask

    // Returns at the falling edge of cycle n; inputs set then are sampled at edge n+1.
    task automatic go_to(input int n);
        if (cyc > n) begin
            errors++;
            $display("FAIL schedule: at cycle %0d, wanted cycle %0d", cyc, n);
        end
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: compare every scheduled expectation in its cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].n <= cyc) begin
            e = q.pop_front();
            vectors++;
            if (e.n != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d reached at cycle %0d", e.name, e.n, cyc);
            end else if (dig !== e.dig || abcdefg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
                errors++;
                $display("FAIL %s @%0d: got dig=%b seg=%b dp=%b fd=%b, want dig=%b seg=%b dp=%b fd=%b",
                         e.name, cyc, dig, abcdefg, dp, frame_done, e.dig, e.seg, e.dp, e.fd);
            end
        end
    end

    initial begin
        rst = 1'b1; data = '0; dp_in = '0; blank = '0; load = 1'b0; brightness = 4'hF;

        // Reset and first digit-0 slot
        for (int n = 1; n <= 5; n++) dark(n, "rst_idle");
        lit(6, 4'b0001, S0, "rst_first_digit");
        go_to(3); rst = 1'b0;

        // Full-brightness scan of 1234 (committed at the frame-0 end)
        go_to(10);
        push(131, 4'b1000, S0, 1'b1, 1'b1, "scan_fd0_old");
        dark(132, "scan_d0_c0"); dark(133, "scan_d0_c1");
        lit(134, 4'b0001, S4, "scan_d0_c2"); lit(163, 4'b0001, S4, "scan_d0_c31");
        dark(164, "scan_d1_c0"); lit(166, 4'b0010, S3, "scan_d1_c2");
        lit(198, 4'b0100, S2, "tear_d2_old"); lit(230, 4'b1000, S1, "tear_d3_old");
        push(259, 4'b1000, S1, 1'b1, 1'b1, "tear_fd1");
        data = 16'h1234; load = 1'b1;
        go_to(11); load = 1'b0;

        // Mid-frame loads: ABCD at idx 1, then 6789 at idx 2 (latest wins)
        go_to(168);
        lit(262, 4'b0001, S9, "tear_new_d0"); lit(294, 4'b0010, S8, "tear_new_d1");
        lit(326, 4'b0100, S7, "tear_new_d2"); lit(358, 4'b1000, S6, "tear_new_d3");
        data = 16'hABCD; load = 1'b1;
        go_to(169); load = 1'b0;
        go_to(205); data = 16'h6789; load = 1'b1;
        go_to(206); load = 1'b0;

        // Load in the frame-end cycle commits on the same edge
        go_to(386);
        lit(390, 4'b0001, SB, "bypass_d0"); lit(422, 4'b0010, SC, "bypass_d1");
        lit(454, 4'b0100, SD, "bypass_d2"); lit(486, 4'b1000, SE, "bypass_d3");
        data = 16'hEDCB; load = 1'b1;
        go_to(387); load = 1'b0;

        // Brightness 4: lit only for cnt 2..7
        go_to(515);
        dark(517, "pwm_c1"); lit(518, 4'b0001, SB, "pwm_c2"); lit(523, 4'b0001, SB, "pwm_c7");
        dark(524, "pwm_c8"); lit(555, 4'b0010, SC, "pwm_d1_c7"); dark(556, "pwm_d1_c8");
        push(643, 4'b0000, SOFF, 1'b1, 1'b1, "pwm_fd");
        brightness = 4'd4;

        // Brightness 0: dark for the whole frame
        go_to(643);
        for (int n = 644; n <= 771; n++) push(n, 4'b0000, SOFF, 1'b1, n == 771, "bright0");
        brightness = 4'd0;

        // Masks: digit 2 blanked, dp on digit 0 (committed at the frame-5 end)
        go_to(700);
        dark(773, "mask_d0_c1");
        push(774, 4'b0001, S0, 1'b0, 1'b0, "mask_dp_c2");
        push(803, 4'b0001, S0, 1'b0, 1'b0, "mask_dp_c31");
        lit(806, 4'b0010, S1, "mask_d1");
        dark(838, "mask_d2_c2"); dark(856, "mask_d2_c20");
        lit(870, 4'b1000, S3, "mask_d3");
        push(899, 4'b1000, S3, 1'b1, 1'b1, "mask_fd");
        data = 16'h3210; blank = 4'b0100; dp_in = 4'b0001; load = 1'b1;
        go_to(701); load = 1'b0; blank = '0; dp_in = '0;
        go_to(771); brightness = 4'hF;

        // Reset at idx 2, cnt 10 with a load pending
        go_to(900); data = 16'h8888; load = 1'b1;
        go_to(901); load = 1'b0;
        go_to(973);
        dark(974, "mrst_outputs"); dark(975, "mrst_cnt0");
        lit(977, 4'b0001, S0, "mrst_d0");
        lit(1041, 4'b0100, S0, "mrst_unblank_d2");
        push(1102, 4'b1000, S0, 1'b1, 1'b1, "mrst_fd");
        lit(1105, 4'b0001, S0, "mrst_discard_d0");
        lit(1201, 4'b1000, S0, "mrst_discard_d3");
        rst = 1'b1;
        go_to(974); rst = 1'b0;

        go_to(1210);
        while (q.size() > 0) begin
            e = q.pop_front();
            errors++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.n);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
        $fatal(1);
    end

endmodule
